// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one bit per clock.
// Start/busy/done handshake; result and final borrow held until the next completion.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic [CntW-1:0]  cnt;
  logic             br;

  logic             bit_x;
  logic             bit_d;
  logic             br_next;

  // Two cascaded half-subtractors: (sa[0] - sb[0]) then (x - br).
  always_comb begin
    bit_x   = sa[0] ^ sb[0];
    bit_d   = bit_x ^ br;
    br_next = (~sa[0] & sb[0]) | (~bit_x & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      sa         <= '0;
      sb         <= '0;
      sd         <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= StRun;
          end else begin
            state <= StIdle;
          end
        end
        StRun: begin
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          sd  <= {bit_d, sd[WIDTH-1:1]};
          br  <= br_next;
          cnt <= cnt + CntW'(1);
          if (cnt == CntLast) begin
            diff       <= {bit_d, sd[WIDTH-1:1]};
            borrow_out <= br_next;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= StDone;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
